versatile_mem_ctrl_wb_arb: RTL
==============================

// Module: versatile_mem_ctrl_wb_arb
// PURPOSE
// - N-port Wishbone B3 front end for the SDRAM controller, single clock domain.
// - Per-port burst FSMs share one egress command/data stream and one ingress read-data stream.
// - A central arbiter holds its grant for a whole burst.
// - Adds over the previous front end: generic widths, explicit burst lengths, round-robin arbitration, early-termination read flush.
// PARAMETERS
// - NR_OF_PORTS  3   number of Wishbone ports (1..8)
// - ADR_WIDTH   36   per-port address word; bits [5]=WE, [4:3]=BTE, [2:0]=CTI, [ADR_WIDTH-1:6]=word address
// - DAT_WIDTH   32   data width, egress and ingress
// - LEN_WIDTH    5   burst length field; must hold MAX_BURST
// - MAX_BURST   16   read length requested for a linear incrementing burst
// PORTS
// - wb_clk          in   1                      the only clock
// - wb_rst_n        in   1                      asynchronous, active-low reset
// - wb_adr_i_v      in   NR_OF_PORTS*ADR_WIDTH  port i at [(N-i)*AW-1:(N-1-i)*AW]
// - wb_dat_i_v      in   NR_OF_PORTS*DAT_WIDTH  write data, same packing
// - wb_stb_i        in   [0:N-1]                strobe per port
// - wb_cyc_i        in   [0:N-1]                cycle per port
// - wb_ack_o        out  [0:N-1]                ack per port
// - wb_dat_o_v      out  NR_OF_PORTS*DAT_WIDTH  read data, broadcast to all ports
// - egress_valid    out  1                      command/data beat valid
// - egress_ready    in   1                      downstream accepts the beat
// - egress_cmd      out  1                      1=address word, 0=write data
// - egress_dat      out  ADR_WIDTH              address word, or write data zero-extended
// - egress_len      out  LEN_WIDTH              read burst length; 0 for writes (with egress_cmd)
// - egress_last     out  1                      final write beat
// - egress_abort    out  1                      1-cycle pulse: write burst dropped before egress_last
// - egress_port     out  $clog2(N)              owner of the current beat
// - ingress_valid   in   1                      read-data beat valid
// - ingress_dat     in   DAT_WIDTH              read data
// - ingress_ready   out  1                      beat consumed
// BEHAVIOUR
// - Reset (wb_rst_n=0, async): all outputs 0, every port FSM IDLE, no grant, round-robin pointer=0.
// - Request: port i requests in IDLE when cyc&stb. The arbiter grants in ARB cycle 0; the grant is held until the owner returns to IDLE.
// - Port FSM states: IDLE, ADR, WR, RD, FE.
//   - IDLE->ADR on grant.
//   - ADR: present the address word (egress_cmd=1); no wb ack. On the handshake go to WR if WE, else RD.
//   - Read length: classic (CTI=000) ->1; CTI=010 -> BTE wrap4/8/16 = 4/8/16, linear=MAX_BURST.
//   - WR: egress_valid=cyc&stb; wb_ack_o = egress_valid&egress_ready (combinational).
//     - egress_last on the acked beat with CTI 000/111 -> IDLE.
//     - cyc low before last: pulse egress_abort, -> IDLE.
//   - RD: beat counter loaded with len; ingress_ready=stb&cyc.
//     - On each ingress handshake, register the data; wb_ack_o is asserted the next cycle (1-cycle latency); counter decrements.
//     - Counter reaches 0 -> IDLE.
//     - CTI=111 acked, or cyc low, while counter>0 -> FE.
//   - FE: ingress_ready=1, data discarded, no ack; counter reaches 0 -> IDLE.
// - Only the granted port drives egress/ingress; other ports see ack=0.
// - Simultaneous: egress_abort and a new request from another port in the same cycle -> abort first, regrant the next cycle.
// - ingress_valid while no port is in RD/FE: ignored, ingress_ready=0.
// - Counter underflow is impossible; MAX_BURST > 2**LEN_WIDTH-1 is an elaboration error.
// CONFIGURATION
// - VMC_WB_ARB_RR_EN defined: round-robin; search starts at last owner+1, wrapping N-1 -> 0.
// - Not defined: fixed priority, port 0 highest (previous ordering); pointer logic removed.
// STRUCTURE
// - Shared package versatile_mem_ctrl_pkg:
//   - CTI/BTE encodings (classic, incr, endofburst, linear, wrap4/8/16)
//   - port-FSM state enum
//   - function burst_len(cti,bte) -> LEN_WIDTH
// - Sub-module wb_port_fsm: one instance per port (generate). Top level keeps the arbiter and egress/ingress muxing.
// TESTING
// - Reset mid-burst: drop wb_rst_n during a 4-beat write -> all outputs 0 the same cycle; IDLE after release.
// - Port1 classic write, adr 0x40, dat 0xDEADBEEF, egress_ready=1 ->
//   - cmd beat with egress_len=0, then data beat with egress_last=1;
//   - ack_o[1] on the data beat only.
// - Port0 read, CTI=010, BTE=wrap8 ->
//   - egress_len=8;
//   - 8 ingress beats 0..7 -> 8 acks, each 1 cycle after its beat, data 0..7 in order.
// - Port2 read, linear burst, CTI=111 after 3 acks ->
//   - FE state drains the remaining 13 beats with no ack;
//   - port2 then returns to IDLE.
// - RR_EN: ports 0,1,2 request continuously with classic reads -> grant order 0,1,2,0;
//   - without RR_EN: 0,0,0 while port 0 keeps requesting.
// - Write, cyc dropped after 2 of 4 beats -> egress_abort pulses once with egress_port=owner; no egress_last.

Source files
------------

// File: rtl/versatile_mem_ctrl_pkg.sv
// Shared definitions for the versatile memory controller Wishbone front end:
// cycle-type / burst-type encodings, port FSM states and read burst length decode.
package versatile_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR,
    ST_WR,
    ST_RD,
    ST_FE
  } port_state_e;

  // Result is wide enough for any legal LEN_WIDTH; callers truncate to their field.
  function automatic logic [7:0] burst_len(input logic [2:0] cti, input logic [1:0] bte,
                                           input logic [7:0] max_burst);
    burst_len = 8'd1;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_WRAP4:  burst_len = 8'd4;
        BTE_WRAP8:  burst_len = 8'd8;
        BTE_WRAP16: burst_len = 8'd16;
        default:    burst_len = max_burst;
      endcase
    end
  endfunction

endpackage

// File: rtl/wb_port_fsm.sv
// Per-port Wishbone burst FSM: presents the address word, streams write data,
// and counts read beats (acking with one cycle latency, flushing on early end).
module wb_port_fsm
  import versatile_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 36,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 5,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [DAT_WIDTH-1:0] dat,
  input  logic                 stb,
  input  logic                 cyc,
  input  logic                 grant,
  input  logic                 egress_ready,
  input  logic                 ingress_valid,
  output logic                 req,
  output logic                 busy,
  output logic                 ack,
  output logic                 egress_valid,
  output logic                 egress_cmd,
  output logic [ADR_WIDTH-1:0] egress_dat,
  output logic [LEN_WIDTH-1:0] egress_len,
  output logic                 egress_last,
  output logic                 egress_abort,
  output logic                 ingress_ready,
  output logic                 rd_take
);

  port_state_e          state;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 ack_r;
  logic                 wr_ack;
  logic                 rd_term;
  logic [LEN_WIDTH-1:0] req_len;
  logic [2:0]           cti;
  logic                 we;

  assign cti     = adr[2:0];
  assign we      = adr[5];
  assign req_len = LEN_WIDTH'(burst_len(adr[2:0], adr[4:3], 8'(MAX_BURST)));

  always_comb begin
    egress_valid  = 1'b0;
    egress_cmd    = 1'b0;
    egress_dat    = '0;
    egress_len    = '0;
    egress_last   = 1'b0;
    egress_abort  = 1'b0;
    ingress_ready = 1'b0;
    wr_ack        = 1'b0;
    rd_term       = 1'b0;
    rd_take       = 1'b0;
    case (state)
      ST_ADR: begin
        egress_valid = 1'b1;
        egress_cmd   = 1'b1;
        egress_dat   = adr;
        egress_len   = we ? '0 : req_len;
      end
      ST_WR: begin
        egress_valid = cyc & stb;
        egress_dat   = ADR_WIDTH'(dat);
        wr_ack       = egress_valid & egress_ready;
        egress_last  = wr_ack & ((cti == CTI_CLASSIC) | (cti == CTI_EOB));
        egress_abort = ~cyc;
      end
      ST_RD: begin
        // The ack currently on the bus carrying end-of-burst closes the transfer.
        rd_term       = ~cyc | (ack_r & (cti == CTI_EOB));
        ingress_ready = cyc & stb & ~rd_term;
        rd_take       = ingress_ready & ingress_valid;
      end
      ST_FE:   ingress_ready = 1'b1;
      default: ;
    endcase
  end

  assign ack  = ack_r | wr_ack;
  assign req  = (state == ST_IDLE) & cyc & stb;
  assign busy = (state != ST_IDLE) | ack_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack_r <= 1'b0;
    end else begin
      ack_r <= rd_take;
      case (state)
        ST_IDLE: if (grant) state <= ST_ADR;
        ST_ADR: begin
          if (egress_ready) begin
            if (we) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
              cnt   <= req_len;
            end
          end
        end
        ST_WR: if (!cyc || egress_last) state <= ST_IDLE;
        ST_RD: begin
          if (rd_take) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_WIDTH'(1)) state <= ST_IDLE;
          end else if (rd_term) begin
            state <= ST_FE;
          end
        end
        ST_FE: begin
          if (ingress_valid) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_WIDTH'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/versatile_mem_ctrl_wb_arb.sv
// N-port Wishbone front end: burst-holding arbiter plus egress/ingress muxing.
// VMC_WB_ARB_RR_EN selects round-robin; otherwise fixed priority, port 0 highest.
module versatile_mem_ctrl_wb_arb
  import versatile_mem_ctrl_pkg::*;
#(
  parameter  int unsigned NR_OF_PORTS = 3,
  parameter  int unsigned ADR_WIDTH   = 36,
  parameter  int unsigned DAT_WIDTH   = 32,
  parameter  int unsigned LEN_WIDTH   = 5,
  parameter  int unsigned MAX_BURST   = 16,
  localparam int unsigned PORT_W      = (NR_OF_PORTS > 1) ? $clog2(NR_OF_PORTS) : 1
) (
  input  logic                             wb_clk,
  input  logic                             wb_rst_n,
  input  logic [NR_OF_PORTS*ADR_WIDTH-1:0] wb_adr_i_v,
  input  logic [NR_OF_PORTS*DAT_WIDTH-1:0] wb_dat_i_v,
  input  logic [0:NR_OF_PORTS-1]           wb_stb_i,
  input  logic [0:NR_OF_PORTS-1]           wb_cyc_i,
  output logic [0:NR_OF_PORTS-1]           wb_ack_o,
  output logic [NR_OF_PORTS*DAT_WIDTH-1:0] wb_dat_o_v,
  output logic                             egress_valid,
  input  logic                             egress_ready,
  output logic                             egress_cmd,
  output logic [ADR_WIDTH-1:0]             egress_dat,
  output logic [LEN_WIDTH-1:0]             egress_len,
  output logic                             egress_last,
  output logic                             egress_abort,
  output logic [PORT_W-1:0]                egress_port,
  input  logic                             ingress_valid,
  input  logic [DAT_WIDTH-1:0]             ingress_dat,
  output logic                             ingress_ready
);

  if (MAX_BURST > (2 ** LEN_WIDTH) - 1) begin : g_len_check
    $error("MAX_BURST does not fit in LEN_WIDTH");
  end
  if (NR_OF_PORTS < 1 || NR_OF_PORTS > 8) begin : g_port_check
    $error("NR_OF_PORTS must be 1..8");
  end

  logic [NR_OF_PORTS-1:0] p_req, p_busy, p_ack, p_evalid, p_ecmd, p_elast, p_eabort;
  logic [NR_OF_PORTS-1:0] p_iready, p_rd_take, grant_pulse;
  logic [ADR_WIDTH-1:0]   p_edat [NR_OF_PORTS];
  logic [LEN_WIDTH-1:0]   p_elen [NR_OF_PORTS];

  logic                   grant_valid;
  logic [PORT_W-1:0]      grant_idx;
  logic                   owner_active;
  logic                   found;
  logic [PORT_W-1:0]      win;
  logic [DAT_WIDTH-1:0]   dat_r;
`ifdef VMC_WB_ARB_RR_EN
  logic [PORT_W-1:0]      rr_ptr;
`endif

  for (genvar g = 0; g < NR_OF_PORTS; g++) begin : g_port
    wb_port_fsm #(
      .ADR_WIDTH(ADR_WIDTH),
      .DAT_WIDTH(DAT_WIDTH),
      .LEN_WIDTH(LEN_WIDTH),
      .MAX_BURST(MAX_BURST)
    ) u_fsm (
      .clk          (wb_clk),
      .rst_n        (wb_rst_n),
      .adr          (wb_adr_i_v[(NR_OF_PORTS-g)*ADR_WIDTH-1 -: ADR_WIDTH]),
      .dat          (wb_dat_i_v[(NR_OF_PORTS-g)*DAT_WIDTH-1 -: DAT_WIDTH]),
      .stb          (wb_stb_i[g]),
      .cyc          (wb_cyc_i[g]),
      .grant        (grant_pulse[g]),
      .egress_ready (egress_ready),
      .ingress_valid(ingress_valid),
      .req          (p_req[g]),
      .busy         (p_busy[g]),
      .ack          (p_ack[g]),
      .egress_valid (p_evalid[g]),
      .egress_cmd   (p_ecmd[g]),
      .egress_dat   (p_edat[g]),
      .egress_len   (p_elen[g]),
      .egress_last  (p_elast[g]),
      .egress_abort (p_eabort[g]),
      .ingress_ready(p_iready[g]),
      .rd_take      (p_rd_take[g])
    );
    assign wb_ack_o[g]   = p_ack[g];
    assign grant_pulse[g] = ~owner_active & found & (win == PORT_W'(g));
  end

  // The grant stays with its owner until the FSM is idle and its final read ack has gone out.
  assign owner_active = grant_valid & p_busy[grant_idx];

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NR_OF_PORTS; k++) begin
`ifdef VMC_WB_ARB_RR_EN
      idx = (32'(rr_ptr) + k) % NR_OF_PORTS;
`else
      idx = k;
`endif
      if (!found && p_req[idx]) begin
        found = 1'b1;
        win   = PORT_W'(idx);
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
`ifdef VMC_WB_ARB_RR_EN
      rr_ptr      <= '0;
`endif
    end else if (!owner_active) begin
      grant_valid <= found;
      if (found) begin
        grant_idx <= win;
`ifdef VMC_WB_ARB_RR_EN
        rr_ptr    <= (win == PORT_W'(NR_OF_PORTS - 1)) ? '0 : win + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) dat_r <= '0;
    else if (|p_rd_take) dat_r <= ingress_dat;
  end

  assign wb_dat_o_v  = {NR_OF_PORTS{dat_r}};
  assign egress_port = grant_valid ? grant_idx : '0;

  // Non-owner FSMs sit in IDLE with all outputs low, so OR-combining selects the owner.
  always_comb begin
    egress_valid  = 1'b0;
    egress_cmd    = 1'b0;
    egress_dat    = '0;
    egress_len    = '0;
    egress_last   = 1'b0;
    egress_abort  = 1'b0;
    ingress_ready = 1'b0;
    for (int unsigned i = 0; i < NR_OF_PORTS; i++) begin
      egress_valid  = egress_valid  | p_evalid[i];
      egress_cmd    = egress_cmd    | p_ecmd[i];
      egress_dat    = egress_dat    | p_edat[i];
      egress_len    = egress_len    | p_elen[i];
      egress_last   = egress_last   | p_elast[i];
      egress_abort  = egress_abort  | p_eabort[i];
      ingress_ready = ingress_ready | p_iready[i];
    end
  end

endmodule
